riscv_id: RTL and testbench
===========================

# riscv_id

Decode/operand-fetch stage that drives the operand interface of `riscv_ex`. It accepts 32-bit instruction words from fetch and decodes the OP/OP-IMM/LUI subset. It reads a 32×32 register file, which is written back from the EX result port, and issues registered `rdi/a/b/shamt/funct3/invertb` bundles to EX. A per-register scoreboard stalls fetch on read-after-write hazards until the producing result is written back.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch presents `instr`
- in_ready  out  1  stage accepts `instr` this cycle (combinational)
- instr  in  32  RV32I instruction word
- wb_en  in  1  write `wb_data` to register `wb_rd`
- wb_rd  in  5  writeback register index (EX `rd`)
- wb_data  in  32  writeback value (EX `result`)
- out_valid  out  1  EX bundle below is a real instruction
- rdi  out  5  destination register to EX
- a  out  32  operand A
- b  out  32  operand B
- shamt  out  6  shift amount
- funct3  out  3  ALU op (`FUNCT3_*` from isa.v)
- invertb  out  1  SUB / arithmetic-right-shift select
- illegal  out  1  sticky: unsupported opcode seen

## Operation
- Decoded opcodes:
  - OP (0110011): a=x[rs1], b=x[rs2], funct3=instr[14:12], invertb=instr[30].
    - For SLL/SRL/SRA, shamt={1'b0, x[rs2][4:0]}; otherwise shamt=0.
  - OP-IMM (0010011): a=x[rs1], b=sign-extended instr[31:20], funct3=instr[14:12].
    - For SLLI/SRLI/SRAI, shamt={1'b0, instr[24:20]}, b=0, invertb=instr[30].
    - Otherwise shamt=0, invertb=0.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, funct3=`FUNCT3_ADD`, invertb=0, no sources.
- rdi=instr[11:7] for all three opcodes.
- Any other opcode:
  - The instruction is consumed and a bubble is issued.
  - `illegal` is set and held until reset.
- Register file:
  - x0 always reads 0, and writes to x0 are ignored.
  - A read of register r while `wb_en && wb_rd==r` returns `wb_data` (write-through bypass).
- Scoreboard: one pending bit per register.
  - Set for rd≠0 when an instruction is issued.
  - Cleared when `wb_en` targets that register.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard:
  - in_ready=0 when a used source (rs1; rs2 for OP) is pending and is not being cleared by writeback this cycle.
  - x0 is never pending.
- Bubble: out_valid=0, rdi=0, a=0, b=0, shamt=0, funct3=0, invertb=0. A bubble is a NOP for EX.

## Timing
- Reset (rst=0 at an edge):
  - All outputs 0 and in_ready=0 while rst=0.
  - Register file cleared to 0, scoreboard cleared, illegal=0.
- Accept at edge N (in_valid && in_ready) → bundle visible on outputs after edge N, i.e. in cycle N+1. Latency is 1.
- Cycle with no accept (in_valid=0 or stall) → bubble registered at that edge.
- Outputs are not held: EX has no backpressure, each cycle is a new bundle or a bubble.
- Writeback at edge N is visible to a read in the same cycle (bypass) and to all later reads.
- A dependent instruction issues in the same cycle its producer's writeback arrives.
- Reset mid-stall: pending bits clear and the stalled instruction is dropped; fetch must re-present it.

## Test plan
- Reset → all outputs 0, out_valid=0, illegal=0. Release reset → in_ready=1 with in_valid=1 and a hazard-free instr.
- ADDI x4,x0,40 then wb(x4=40); ADD x5,x4,x4 → first bundle rdi=4,a=0,b=40,funct3=ADD. Second bundle stalls until wb, then issues a=40,b=40,rdi=5.
- x2=40 via wb; SUB x3,x2,x1 with x1=5 → a=40,b=5,invertb=1,funct3=ADD, issued 1 cycle after accept.
- SLLI x7,x1,2 with x1=3 → a=3,b=0,shamt=2,funct3=SLL,rdi=7. SRAI x7,x1,31 → shamt=31,invertb=1.
- LUI x9,0xABCDE → a=0,b=32'hABCDE000,rdi=9. Then ADDI x0,x0,1 → rdi=0 and no x0 scoreboard stall on the next read.
- Opcode 0000011 (load) → bubble issued and illegal=1 held. Reset mid-stall (pending x4, dependent waiting) → pending cleared, in_ready=1 after release.

Source files
------------

// File: rtl/riscv_id.sv
// riscv_id: decode / operand-fetch stage feeding riscv_ex.
// Decodes OP, OP-IMM and LUI. Reads a 32x32 register file that is written
// back from the EX result port with write-through bypass. A per-register
// pending scoreboard stalls fetch on read-after-write hazards.
module riscv_id (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [4:0]  rdi,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [5:0]  shamt,
  output logic [2:0]  funct3,
  output logic        invertb,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  logic [31:0] regs [32];
  logic [31:0] pending;

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        is_op;
  logic        is_imm;
  logic        is_lui;
  logic        is_legal;
  logic        use_rs1;
  logic        use_rs2;
  logic        is_shift;
  logic signed [31:0] imm_i;

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] wb_clr;
  logic [31:0] busy;
  logic [31:0] set_mask;
  logic        stall;
  logic        accept;
  logic        issue;

  logic [31:0] a_p0;
  logic [31:0] b_p0;
  logic [5:0]  shamt_p0;
  logic [2:0]  funct3_p0;
  logic        invertb_p0;

  logic        vld_p1;
  logic [4:0]  rdi_p1;
  logic [31:0] a_p1;
  logic [31:0] b_p1;
  logic [5:0]  shamt_p1;
  logic [2:0]  funct3_p1;
  logic        invertb_p1;
  logic        illegal_q;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  assign is_op    = (opcode == OPC_OP);
  assign is_imm   = (opcode == OPC_OP_IMM);
  assign is_lui   = (opcode == OPC_LUI);
  assign is_legal = is_op || is_imm || is_lui;
  assign use_rs1  = is_op || is_imm;
  assign use_rs2  = is_op;
  assign is_shift = (f3 == FUNCT3_SLL) || (f3 == FUNCT3_SR);

  // x0 reads as zero; a same-cycle writeback is forwarded ahead of the array
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

  // A register being written back this cycle no longer blocks its readers
  assign wb_clr   = wb_en ? (32'd1 << wb_rd) : 32'd0;
  assign busy     = pending & ~wb_clr;
  assign stall    = (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]);
  assign in_ready = rst && !stall;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && is_legal;
  assign set_mask = (issue && rd != 5'd0) ? (32'd1 << rd) : 32'd0;

  // Operand selection for the instruction currently presented by fetch
  always_comb begin
    a_p0       = 32'd0;
    b_p0       = 32'd0;
    shamt_p0   = 6'd0;
    funct3_p0  = 3'd0;
    invertb_p0 = 1'b0;
    if (is_op) begin
      a_p0       = rs1_val;
      b_p0       = rs2_val;
      funct3_p0  = f3;
      invertb_p0 = instr[30];
      if (is_shift) begin
        shamt_p0 = {1'b0, rs2_val[4:0]};
      end
    end else if (is_imm) begin
      a_p0      = rs1_val;
      funct3_p0 = f3;
      if (is_shift) begin
        shamt_p0   = {1'b0, instr[24:20]};
        invertb_p0 = instr[30];
      end else begin
        b_p0 = imm_i;
      end
    end else if (is_lui) begin
      b_p0      = {instr[31:12], 12'd0};
      funct3_p0 = FUNCT3_ADD;
    end
  end

  // Register file with clear on reset; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Scoreboard: issue sets after writeback clears, so set wins on collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= 32'd0;
    end else begin
      pending <= (pending & ~wb_clr) | set_mask;
    end
  end

  // p0 -> p1: register the EX bundle; anything not issued becomes a bubble
  always_ff @(posedge clk) begin
    if (!rst || !issue) begin
      vld_p1     <= 1'b0;
      rdi_p1     <= 5'd0;
      a_p1       <= 32'd0;
      b_p1       <= 32'd0;
      shamt_p1   <= 6'd0;
      funct3_p1  <= 3'd0;
      invertb_p1 <= 1'b0;
    end else begin
      vld_p1     <= 1'b1;
      rdi_p1     <= rd;
      a_p1       <= a_p0;
      b_p1       <= b_p0;
      shamt_p1   <= shamt_p0;
      funct3_p1  <= funct3_p0;
      invertb_p1 <= invertb_p0;
    end
  end

  // Sticky flag for a consumed unsupported opcode
  always_ff @(posedge clk) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else if (accept && !is_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign out_valid = vld_p1;
  assign rdi       = rdi_p1;
  assign a         = a_p1;
  assign b         = b_p1;
  assign shamt     = shamt_p1;
  assign funct3    = funct3_p1;
  assign invertb   = invertb_p1;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_id.sv
// Testbench for riscv_id: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the decode stage.
module tb_riscv_id;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] LD  = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        out_valid;
  logic [4:0]  rdi;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  shamt;
  logic [2:0]  funct3;
  logic        invertb;
  logic        illegal;

  always #5 clk = ~clk;

  riscv_id dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .rdi(rdi), .a(a), .b(b), .shamt(shamt),
    .funct3(funct3), .invertb(invertb), .illegal(illegal)
  );

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sh;
    logic [2:0]  f3;
    logic        inv;
  } bundle_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] mregs [32];
  bit          mpend [32];
  bit          mill;
  bit          last_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f3,
                                         input logic [4:0] d);
    return {f7, s2, s1, f3, d, OP};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, IMM};
  endfunction

  // Architectural read as seen by the stage, including same-cycle writeback
  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return mregs[r];
  endfunction

  function automatic bit mbusy(input logic [4:0] r);
    return (r != 0) && mpend[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] x1v,
                                         input logic [31:0] x2v);
    bundle_t o;
    logic [2:0] f3;
    bit shift;
    o = '0;
    f3 = ins[14:12];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    o.v = 1'b1;
    o.rd = ins[11:7];
    case (ins[6:0])
      OP: begin
        o.a = x1v;
        o.b = x2v;
        o.f3 = f3;
        o.inv = ins[30];
        if (shift) o.sh = 6'(x2v % 32);
      end
      IMM: begin
        o.a = x1v;
        o.f3 = f3;
        if (shift) begin
          o.sh = 6'(ins[24:20]);
          o.inv = ins[30];
          o.b = 32'd0;
        end else begin
          o.b = 32'($signed(ins[31:20]));
        end
      end
      default: begin
        o.a = 32'd0;
        o.b = ins & 32'hFFFF_F000;
        o.f3 = 3'd0;
      end
    endcase
    return o;
  endfunction

  // One clock: drive at negedge, check in_ready, advance model, check outputs
  task automatic tick(input bit r, input bit v, input logic [31:0] ins,
                      input bit we, input logic [4:0] wr, input logic [31:0] wd);
    bit legal;
    bit rdy;
    bundle_t nb;
    logic [6:0] opc;
    @(negedge clk);
    rst = r; in_valid = v; instr = ins; wb_en = we; wb_rd = wr; wb_data = wd;
    #1;
    opc = ins[6:0];
    legal = (opc == OP) || (opc == IMM) || (opc == LUI);
    rdy = r && !((opc == OP || opc == IMM) && mbusy(ins[19:15]))
            && !((opc == OP) && mbusy(ins[24:20]));
    check("in_ready", in_ready, rdy);
    last_ready = rdy;
    nb = '0;
    if (!r) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = 32'd0;
        mpend[i] = 1'b0;
      end
      mill = 1'b0;
    end else begin
      if (v && rdy) begin
        if (legal) nb = ref_decode(ins, mread(ins[19:15]), mread(ins[24:20]));
        else mill = 1'b1;
      end
      if (we && wr != 0) mregs[wr] = wd;
      if (we) mpend[wr] = 1'b0;
      if (nb.v && nb.rd != 0) mpend[nb.rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, nb.v);
    check("rdi", rdi, nb.rd);
    check("a", a, nb.a);
    check("b", b, nb.b);
    check("shamt", shamt, nb.sh);
    check("funct3", funct3, nb.f3);
    check("invertb", invertb, nb.inv);
    check("illegal", illegal, mill);
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    k = $urandom_range(0, 39);
    d = 5'($urandom_range(0, 7));
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    if (k == 0) return {25'($urandom), LD};
    if (k < 14) return r_type({1'b0, 1'($urandom_range(0, 1)), 5'd0}, s2, s1, f3, d);
    if (k < 34) return i_type(12'($urandom), s1, f3, d);
    return {20'($urandom), d, LUI};
  endfunction

  initial begin
    logic [31:0] cur;
    bit have;
    bit r, v, we;
    logic [4:0] wr;
    int q[$];

    // Reset
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, i_type(12'd40, 0, 3'd0, 4), 0, 0, 0);
    check("rst_ready", last_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_illegal", illegal, 0);

    // ADDI x4,x0,40 then dependent ADD x5,x4,x4 stalls until wb x4
    tick(1, 1, i_type(12'd40, 0, 3'd0, 4), 0, 0, 0);
    check("rel_ready", last_ready, 1);
    check("addi_rdi", rdi, 4);
    check("addi_b", b, 40);
    check("addi_f3", funct3, 0);
    tick(1, 1, r_type(7'd0, 4, 4, 3'd0, 5), 0, 0, 0);
    check("raw_stall", last_ready, 0);
    check("raw_bubble", out_valid, 0);
    tick(1, 1, r_type(7'd0, 4, 4, 3'd0, 5), 1, 4, 40);
    check("raw_wb_ready", last_ready, 1);
    check("add_a", a, 40);
    check("add_b", b, 40);
    check("add_rdi", rdi, 5);

    // SUB x3,x2,x1 with x2=40, x1=5
    tick(1, 0, 0, 1, 2, 40);
    tick(1, 0, 0, 1, 1, 5);
    tick(1, 0, 0, 1, 5, 80);
    tick(1, 1, r_type(7'h20, 1, 2, 3'd0, 3), 0, 0, 0);
    check("sub_a", a, 40);
    check("sub_b", b, 5);
    check("sub_inv", invertb, 1);

    // Immediate shifts with x1=3
    tick(1, 0, 0, 1, 1, 3);
    tick(1, 0, 0, 1, 3, 35);
    tick(1, 1, i_type(12'd2, 1, 3'd1, 7), 0, 0, 0);
    check("slli_a", a, 3);
    check("slli_b", b, 0);
    check("slli_sh", shamt, 2);
    check("slli_f3", funct3, 1);
    tick(1, 1, i_type(12'h41F, 1, 3'd5, 7), 0, 0, 0);
    check("srai_sh", shamt, 31);
    check("srai_inv", invertb, 1);

    // LUI, write to x0, and no x0 stall afterwards
    tick(1, 1, {20'hABCDE, 5'd9, LUI}, 0, 0, 0);
    check("lui_b", b, 32'hABCDE000);
    check("lui_rdi", rdi, 9);
    tick(1, 1, i_type(12'd1, 0, 3'd0, 0), 0, 0, 0);
    check("x0_rdi", rdi, 0);
    tick(1, 1, r_type(7'd0, 0, 0, 3'd0, 6), 0, 0, 0);
    check("x0_ready", last_ready, 1);

    // Unsupported opcode
    tick(1, 1, {25'h12345, LD}, 0, 0, 0);
    check("ld_bubble", out_valid, 0);
    check("ld_illegal", illegal, 1);
    tick(1, 0, 0, 0, 0, 0);
    check("ill_sticky", illegal, 1);

    // Reset while a dependent instruction is stalled
    tick(1, 1, i_type(12'd1, 0, 3'd0, 4), 0, 0, 0);
    tick(1, 1, r_type(7'd0, 4, 4, 3'd0, 5), 0, 0, 0);
    check("ms_stall", last_ready, 0);
    tick(0, 1, r_type(7'd0, 4, 4, 3'd0, 5), 0, 0, 0);
    check("ms_rst_ready", last_ready, 0);
    tick(1, 1, r_type(7'd0, 4, 4, 3'd0, 5), 0, 0, 0);
    check("ms_rel_ready", last_ready, 1);
    check("ms_a", a, 0);
    check("ms_illegal", illegal, 0);

    // Random traffic
    have = 1'b0;
    cur = 32'd0;
    repeat (3000) begin
      r = ($urandom_range(0, 299) != 0);
      if (!have) begin
        cur = rand_instr();
        have = 1'b1;
      end
      v = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      q.delete();
      for (int i = 1; i < 8; i++) if (mpend[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 2) != 0)
        wr = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        wr = 5'($urandom_range(0, 7));
      tick(r, v, cur, we, wr, $urandom);
      if (v && last_ready) have = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
